// File: rtl/trashbin_bus_pkg.sv
// Shared definitions for the core-to-SRAM memory bus controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package trashbin_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } bus_state_t;

    localparam int          DEFAULT_ADDR_WIDTH  = 12;
    localparam int          DEFAULT_WAIT_STATES = 1;
    // Value returned to the core for a read outside the RAM window.
    localparam logic [31:0] OOR_READ_VALUE      = 32'h0;

endpackage

// File: rtl/bus_wait_counter.sv
// Wait-state counter: loadable down-counter with a zero flag.
// Latency: load/decrement take effect on the next rising edge.
// Backpressure: none; holds at zero once reached.
//
// Ports: clk, rst (async active-high), load + load_value (preset),
//        dec (count down when nonzero), zero (count == 0).
module bus_wait_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/memory_bus_controller.sv
// Memory bus controller: serves single core read/write requests against a synchronous SRAM.
// Latency: request sampled at edge E -> OK pulse between edges E+WAIT_STATES+1 and E+WAIT_STATES+2.
// Backpressure: requests are only sampled in IDLE; the core holds request/data until OK.
//
// Ports: CoreClock/CoreReset; core side AddressBus, ReadAssert, WriteAssert, DataWriteBus,
//        DataReadBus, ReadOK, WriteOK, BusError; SRAM side RamAddress, RamWriteData,
//        RamChipEnable, RamWriteEnable, RamReadData.
module memory_bus_controller
    import trashbin_bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
    input  logic                  CoreClock,
    input  logic                  CoreReset,
    input  logic [31:0]           AddressBus,
    input  logic                  ReadAssert,
    input  logic                  WriteAssert,
    input  logic [31:0]           DataWriteBus,
    output logic [31:0]           DataReadBus,
    output logic                  ReadOK,
    output logic                  WriteOK,
    output logic                  BusError,
    output logic [ADDR_WIDTH-1:0] RamAddress,
    output logic [31:0]           RamWriteData,
    output logic                  RamChipEnable,
    output logic                  RamWriteEnable,
    input  logic [31:0]           RamReadData
);

    bus_state_t state;
    logic       lat_write;   // latched request is a write (write wins over read)
    logic       lat_err;     // latched request was outside the RAM window
    logic       req;
    logic       req_oor;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_zero;

    assign req      = ReadAssert | WriteAssert;
    assign req_oor  = (AddressBus >> ADDR_WIDTH) != 32'd0;
    assign cnt_load = (state == ST_IDLE) && req;
    assign cnt_dec  = (state == ST_ACCESS);

    // ACCESS lasts 1+WAIT_STATES cycles: the counter is preset to WAIT_STATES
    // on entry and the exit edge is the one that sees it at zero.
    bus_wait_counter #(
        .WIDTH(4)
    ) u_wait (
        .clk       (CoreClock),
        .rst       (CoreReset),
        .load      (cnt_load),
        .load_value(4'(WAIT_STATES)),
        .dec       (cnt_dec),
        .zero      (cnt_zero)
    );

    always_ff @(posedge CoreClock or posedge CoreReset) begin
        if (CoreReset) begin
            state          <= ST_IDLE;
            lat_write      <= 1'b0;
            lat_err        <= 1'b0;
            DataReadBus    <= '0;
            ReadOK         <= 1'b0;
            WriteOK        <= 1'b0;
            BusError       <= 1'b0;
            RamAddress     <= '0;
            RamWriteData   <= '0;
            RamChipEnable  <= 1'b0;
            RamWriteEnable <= 1'b0;
        end else begin
            // Pulses and RAM strobes are single-cycle; RAM outputs idle at zero.
            ReadOK         <= 1'b0;
            WriteOK        <= 1'b0;
            BusError       <= 1'b0;
            RamAddress     <= '0;
            RamWriteData   <= '0;
            RamChipEnable  <= 1'b0;
            RamWriteEnable <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state     <= ST_ACCESS;
                        lat_write <= WriteAssert;
                        lat_err   <= req_oor;
                        // Strobe is registered here so it is high exactly in the
                        // first ACCESS cycle; out-of-range requests never touch RAM.
                        if (!req_oor) begin
                            RamChipEnable  <= 1'b1;
                            RamWriteEnable <= WriteAssert;
                            RamAddress     <= AddressBus[ADDR_WIDTH-1:0];
                            RamWriteData   <= WriteAssert ? DataWriteBus : 32'h0;
                        end
                    end
                end

                ST_ACCESS: begin
                    if (cnt_zero) begin
                        state    <= ST_RESPOND;
                        ReadOK   <= !lat_write;
                        WriteOK  <= lat_write;
                        BusError <= lat_err;
                        if (!lat_write) begin
                            DataReadBus <= lat_err ? OOR_READ_VALUE : RamReadData;
                        end
                    end
                end

                ST_RESPOND: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_bus_controller.sv
// Testbench for memory_bus_controller: two instances (WAIT_STATES 1 and 4) on behavioural SRAMs.
// Latency: n/a.
// Backpressure: n/a.
module tb_memory_bus_controller;

    typedef struct packed {
        int ce_n;
        int we_n;
        int ok_cyc;
        int ok_n;
        int rok_n;
        int wok_n;
        int err_n;
        int stray_err;
        int bad_ram;
    } obs_t;

    typedef struct packed {
        int          ce_n;
        int          we_n;
        int          ok_cyc;
        bit          rok;
        bit          wok;
        bit          err;
        logic [31:0] rd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] addr   [2];
    logic        rd     [2];
    logic        wr     [2];
    logic [31:0] wdat   [2];
    logic [31:0] rdbus  [2];
    logic        rok    [2];
    logic        wok    [2];
    logic        berr   [2];
    logic [11:0] ram_a  [2];
    logic [31:0] ram_wd [2];
    logic        ce     [2];
    logic        we     [2];
    logic [31:0] ram_rd [2];

    logic [31:0] sram    [2][4096];
    logic [31:0] ref_mem [2][4096];
    logic [31:0] exp_rd  [2];

    logic        pl_en;
    int          pl_u;
    logic [11:0] pl_a;
    logic [31:0] pl_d;

    int chk_cnt;
    int pass_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        memory_bus_controller #(
            .ADDR_WIDTH (12),
            .WAIT_STATES((g == 0) ? 1 : 4)
        ) dut (
            .CoreClock     (clk),
            .CoreReset     (rst),
            .AddressBus    (addr[g]),
            .ReadAssert    (rd[g]),
            .WriteAssert   (wr[g]),
            .DataWriteBus  (wdat[g]),
            .DataReadBus   (rdbus[g]),
            .ReadOK        (rok[g]),
            .WriteOK       (wok[g]),
            .BusError      (berr[g]),
            .RamAddress    (ram_a[g]),
            .RamWriteData  (ram_wd[g]),
            .RamChipEnable (ce[g]),
            .RamWriteEnable(we[g]),
            .RamReadData   (ram_rd[g])
        );
    end

    // Synchronous SRAMs: read data appears after the enabling edge and holds.
    always @(posedge clk) begin
        if (pl_en) sram[pl_u][pl_a] <= pl_d;
        for (int g = 0; g < 2; g++) begin
            if (ce[g]) begin
                if (we[g]) sram[g][ram_a[g]] <= ram_wd[g];
                else       ram_rd[g] <= sram[g][ram_a[g]];
            end
        end
    end

    // Reference model: what one request should do, from the access rules alone.
    task automatic model_access(input int uu, input bit r, input bit w,
                                input logic [31:0] a, input logic [31:0] d, output exp_t e);
        bit oor;
        oor      = (a >= 32'd4096);
        e.ce_n   = oor ? 0 : 1;
        e.we_n   = (w && !oor) ? 1 : 0;
        e.ok_cyc = ((uu == 0) ? 1 : 4) + 1;
        e.wok    = w;
        e.rok    = r && !w;
        e.err    = oor;
        if (w && !oor) ref_mem[uu][a[11:0]] = d;
        if (!w) exp_rd[uu] = oor ? 32'h0 : ref_mem[uu][a[11:0]];
        e.rd = exp_rd[uu];
    endtask

    // Drive one request, drop it on OK, and record what the DUT did.
    // c counts cycles after the sampling edge E (c=0 is the first ACCESS cycle).
    task automatic do_access(input int uu, input bit r, input bit w,
                             input logic [31:0] a, input logic [31:0] d, output obs_t o);
        int ws;
        ws = (uu == 0) ? 1 : 4;
        o = '0;
        o.ok_cyc = -1;
        @(negedge clk);
        addr[uu] = a; rd[uu] = r; wr[uu] = w; wdat[uu] = d;
        for (int c = 0; c <= ws + 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ce[uu]) begin
                o.ce_n++;
                if (ram_a[uu] !== a[11:0]) o.bad_ram++;
                if (we[uu] && ram_wd[uu] !== d) o.bad_ram++;
            end else if (we[uu] || ram_a[uu] !== 12'd0 || ram_wd[uu] !== 32'd0) begin
                o.bad_ram++;
            end
            if (we[uu]) o.we_n++;
            if (rok[uu] || wok[uu]) begin
                o.ok_n++;
                if (o.ok_cyc < 0) o.ok_cyc = c;
                if (rok[uu]) o.rok_n++;
                if (wok[uu]) o.wok_n++;
                if (berr[uu]) o.err_n++;
                rd[uu] = 1'b0;
                wr[uu] = 1'b0;
            end else if (berr[uu]) begin
                o.stray_err++;
            end
        end
        rd[uu] = 1'b0;
        wr[uu] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        pl_en = 1'b1;
        for (int uu = 0; uu < 2; uu++) begin
            for (int i = 0; i < 64; i++) begin
                @(negedge clk);
                pl_u = uu;
                pl_a = 12'(i);
                pl_d = (uu == 0 && i == 5) ? 32'h12345678 : $urandom;
                ref_mem[uu][i] = pl_d;
            end
        end
        @(negedge clk);
        pl_en = 1'b0;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        for (int uu = 0; uu < 2; uu++) begin
            chk_cnt++;
            if ({rok[uu], wok[uu], berr[uu], ce[uu], we[uu]} !== 5'b0)
                $display("FAIL reset_strobes u%0d: got %b want 00000", uu,
                         {rok[uu], wok[uu], berr[uu], ce[uu], we[uu]});
            else pass_cnt++;
            chk_cnt++;
            if (rdbus[uu] !== 32'h0)
                $display("FAIL reset_rdbus u%0d: got %h want 0", uu, rdbus[uu]);
            else pass_cnt++;
            chk_cnt++;
            if (ram_a[uu] !== 12'h0 || ram_wd[uu] !== 32'h0)
                $display("FAIL reset_ram_out u%0d: got %h/%h want 0/0", uu, ram_a[uu], ram_wd[uu]);
            else pass_cnt++;
        end
        rst = 1'b0;
    endtask

    task automatic test_read_basic;
        obs_t o; exp_t e;
        model_access(0, 1'b1, 1'b0, 32'h5, 32'h0, e);
        do_access(0, 1'b1, 1'b0, 32'h5, 32'h0, o);
        chk_cnt++;
        if (o.ce_n !== 1) $display("FAIL read5_strobes: got %0d want 1", o.ce_n); else pass_cnt++;
        chk_cnt++;
        if (o.ok_cyc !== 2) $display("FAIL read5_latency: got %0d want 2", o.ok_cyc); else pass_cnt++;
        chk_cnt++;
        if (o.rok_n !== 1 || o.wok_n !== 0 || o.ok_n !== 1)
            $display("FAIL read5_ok: got r%0d w%0d want r1 w0", o.rok_n, o.wok_n);
        else pass_cnt++;
        chk_cnt++;
        if (rdbus[0] !== 32'h12345678) $display("FAIL read5_data: got %h want 12345678", rdbus[0]);
        else pass_cnt++;
    endtask

    task automatic test_write_read;
        obs_t o; exp_t e;
        model_access(0, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D, e);
        do_access(0, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D, o);
        chk_cnt++;
        if (o.wok_n !== 1 || o.rok_n !== 0) $display("FAIL wr10_ok: got w%0d r%0d want w1 r0", o.wok_n, o.rok_n);
        else pass_cnt++;
        chk_cnt++;
        if (o.we_n !== 1 || o.bad_ram !== 0) $display("FAIL wr10_we: got we%0d bad%0d want 1/0", o.we_n, o.bad_ram);
        else pass_cnt++;
        model_access(0, 1'b1, 1'b0, 32'h10, 32'h0, e);
        do_access(0, 1'b1, 1'b0, 32'h10, 32'h0, o);
        chk_cnt++;
        if (rdbus[0] !== 32'hCAFEF00D) $display("FAIL rd10_data: got %h want cafef00d", rdbus[0]);
        else pass_cnt++;
    endtask

    task automatic test_both_asserted;
        obs_t o; exp_t e;
        model_access(0, 1'b1, 1'b1, 32'h3, 32'hA5A5A5A5, e);
        do_access(0, 1'b1, 1'b1, 32'h3, 32'hA5A5A5A5, o);
        chk_cnt++;
        if (o.wok_n !== 1 || o.rok_n !== 0) $display("FAIL both_ok: got w%0d r%0d want w1 r0", o.wok_n, o.rok_n);
        else pass_cnt++;
        chk_cnt++;
        if (sram[0][3] !== 32'hA5A5A5A5) $display("FAIL both_ram: got %h want a5a5a5a5", sram[0][3]);
        else pass_cnt++;
        chk_cnt++;
        if (rdbus[0] !== 32'hCAFEF00D) $display("FAIL both_rdbus: got %h want cafef00d", rdbus[0]);
        else pass_cnt++;
    endtask

    task automatic test_out_of_range;
        obs_t o; exp_t e;
        model_access(0, 1'b1, 1'b0, 32'h0001_0000, 32'h0, e);
        do_access(0, 1'b1, 1'b0, 32'h0001_0000, 32'h0, o);
        chk_cnt++;
        if (o.ce_n !== 0) $display("FAIL oor_rd_strobe: got %0d want 0", o.ce_n); else pass_cnt++;
        chk_cnt++;
        if (rdbus[0] !== 32'h0) $display("FAIL oor_rd_data: got %h want 0", rdbus[0]); else pass_cnt++;
        chk_cnt++;
        if (o.err_n !== 1 || o.stray_err !== 0 || o.rok_n !== 1)
            $display("FAIL oor_rd_err: got err%0d stray%0d rok%0d want 1/0/1", o.err_n, o.stray_err, o.rok_n);
        else pass_cnt++;
        chk_cnt++;
        if (o.ok_cyc !== 2) $display("FAIL oor_rd_latency: got %0d want 2", o.ok_cyc); else pass_cnt++;
        model_access(0, 1'b0, 1'b1, 32'h0000_1005, 32'h0BAD0BAD, e);
        do_access(0, 1'b0, 1'b1, 32'h0000_1005, 32'h0BAD0BAD, o);
        chk_cnt++;
        if (o.ce_n !== 0 || o.wok_n !== 1 || o.err_n !== 1)
            $display("FAIL oor_wr: got ce%0d wok%0d err%0d want 0/1/1", o.ce_n, o.wok_n, o.err_n);
        else pass_cnt++;
        chk_cnt++;
        if (sram[0][5] !== 32'h12345678) $display("FAIL oor_wr_ram: got %h want 12345678", sram[0][5]);
        else pass_cnt++;
    endtask

    // Request held through OK: re-served from IDLE after RESPOND (WAIT_STATES=1).
    task automatic test_back_to_back;
        exp_t e;
        int ce_c[$];
        int ok_c[$];
        model_access(0, 1'b1, 1'b0, 32'h7, 32'h0, e);
        model_access(0, 1'b1, 1'b0, 32'h7, 32'h0, e);
        @(negedge clk);
        addr[0] = 32'h7; rd[0] = 1'b1; wr[0] = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ce[0]) ce_c.push_back(c);
            if (rok[0] || wok[0]) begin
                ok_c.push_back(c);
                if (ok_c.size() >= 2) rd[0] = 1'b0;
            end
        end
        rd[0] = 1'b0;
        chk_cnt++;
        if (ce_c.size() !== 2) $display("FAIL b2b_strobes: got %0d want 2", ce_c.size());
        else pass_cnt++;
        chk_cnt++;
        if (ok_c.size() !== 2) $display("FAIL b2b_oks: got %0d want 2", ok_c.size());
        else pass_cnt++;
        if (ce_c.size() == 2 && ok_c.size() == 2) begin
            chk_cnt++;
            if (ce_c[0] !== 0 || ce_c[1] !== 4 || ok_c[0] !== 2 || ok_c[1] !== 6)
                $display("FAIL b2b_timing: got ce %0d,%0d ok %0d,%0d want 0,4 2,6",
                         ce_c[0], ce_c[1], ok_c[0], ok_c[1]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (rdbus[0] !== e.rd) $display("FAIL b2b_data: got %h want %h", rdbus[0], e.rd);
        else pass_cnt++;
    endtask

    task automatic test_random;
        obs_t o; exp_t e;
        int uu;
        bit r, w;
        logic [31:0] a, d;
        for (int i = 0; i < 32; i++) begin
            uu = (i % 4 == 3) ? 1 : 0;
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            if (!r && !w) r = 1'b1;
            if ($urandom_range(0, 4) == 0) a = (32'($urandom_range(1, 1000)) << 12) | 32'($urandom_range(0, 63));
            else                           a = 32'($urandom_range(0, 63));
            d = $urandom;
            model_access(uu, r, w, a, d, e);
            do_access(uu, r, w, a, d, o);
            chk_cnt++;
            if (o.ce_n !== e.ce_n || o.bad_ram !== 0)
                $display("FAIL rand%0d_strobe: got %0d bad%0d want %0d", i, o.ce_n, o.bad_ram, e.ce_n);
            else pass_cnt++;
            chk_cnt++;
            if (o.we_n !== e.we_n) $display("FAIL rand%0d_we: got %0d want %0d", i, o.we_n, e.we_n);
            else pass_cnt++;
            chk_cnt++;
            if (o.ok_cyc !== e.ok_cyc || o.ok_n !== 1)
                $display("FAIL rand%0d_latency: got %0d n%0d want %0d n1", i, o.ok_cyc, o.ok_n, e.ok_cyc);
            else pass_cnt++;
            chk_cnt++;
            if (o.rok_n !== int'(e.rok) || o.wok_n !== int'(e.wok))
                $display("FAIL rand%0d_kind: got r%0d w%0d want r%0d w%0d", i, o.rok_n, o.wok_n, e.rok, e.wok);
            else pass_cnt++;
            chk_cnt++;
            if (o.err_n !== int'(e.err) || o.stray_err !== 0)
                $display("FAIL rand%0d_err: got %0d stray%0d want %0d", i, o.err_n, o.stray_err, e.err);
            else pass_cnt++;
            chk_cnt++;
            if (rdbus[uu] !== e.rd) $display("FAIL rand%0d_data: got %h want %h", i, rdbus[uu], e.rd);
            else pass_cnt++;
        end
    endtask

    // WAIT_STATES=4 write aborted by reset in its second ACCESS cycle.
    task automatic test_reset_abort;
        obs_t o; exp_t e;
        int ok_seen;
        @(negedge clk);
        addr[1] = 32'h20; wr[1] = 1'b1; rd[1] = 1'b0; wdat[1] = 32'hDEADBEEF;
        @(posedge clk);          // E: request sampled
        @(posedge clk);          // E+1: RAM strobe lands, second ACCESS cycle begins
        #2 rst = 1'b1;
        wr[1] = 1'b0;
        #1;
        chk_cnt++;
        if ({rok[1], wok[1], berr[1], ce[1], we[1]} !== 5'b0 || rdbus[1] !== 32'h0 ||
            ram_a[1] !== 12'h0 || ram_wd[1] !== 32'h0)
            $display("FAIL abort_outputs: got %b rd=%h want all zero",
                     {rok[1], wok[1], berr[1], ce[1], we[1]}, rdbus[1]);
        else pass_cnt++;
        // The strobe went out before the reset, so the write is in RAM.
        ref_mem[1][12'h20] = 32'hDEADBEEF;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        ok_seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (rok[1] || wok[1] || ce[1]) ok_seen++;
        end
        chk_cnt++;
        if (ok_seen !== 0) $display("FAIL abort_no_ok: got %0d activity cycles want 0", ok_seen);
        else pass_cnt++;
        model_access(1, 1'b1, 1'b0, 32'h20, 32'h0, e);
        do_access(1, 1'b1, 1'b0, 32'h20, 32'h0, o);
        chk_cnt++;
        if (o.ok_cyc !== 5 || o.rok_n !== 1 || o.ce_n !== 1)
            $display("FAIL abort_reread: got cyc%0d rok%0d ce%0d want 5/1/1", o.ok_cyc, o.rok_n, o.ce_n);
        else pass_cnt++;
        chk_cnt++;
        if (rdbus[1] !== 32'hDEADBEEF) $display("FAIL abort_reread_data: got %h want deadbeef", rdbus[1]);
        else pass_cnt++;
    endtask

    initial begin
        chk_cnt = 0;
        pass_cnt = 0;
        rst = 1'b1;
        pl_en = 1'b0; pl_u = 0; pl_a = '0; pl_d = '0;
        for (int g = 0; g < 2; g++) begin
            addr[g] = '0; rd[g] = 1'b0; wr[g] = 1'b0; wdat[g] = '0;
        end
        test_reset();
        test_read_basic();
        test_write_read();
        test_both_asserted();
        test_out_of_range();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
